motor_ramp_sequencer: RTL and testbench
=======================================

# motor_ramp_sequencer

Command-driven sequencer for the brushed-motor drive: direction pair plus PWM enable. It accepts speed/direction commands over a valid/ready handshake and ramps PWM duty toward the commanded target once per PWM period. On any direction change or stop it ramps to zero, then holds both direction lines low for a dead-time before re-driving. It sits between the switch/command decode logic and the MOTOR pins, and replaces direct switch-to-pin drive.

## Interface
- PERIOD, 1000000: PWM period in clk cycles.
- DUTY_SLOW, 200000: high-time target for slow speed.
- DUTY_FAST, 900000: high-time target for fast speed.
- RAMP_STEP, 50000: maximum duty change per period.
- DEAD_PERIODS, 10: whole PWM periods with direction lines at 00 before reversal, restart or idle.
- clk, in, 1: single clock; all logic is on the rising edge.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- cmd_valid, in, 1: command present.
- cmd_ready, out, 1: block can accept a command.
- cmd_dir, in, 2: 01 forward, 10 reverse, 00 or 11 stop.
- cmd_fast, in, 1: 1 selects DUTY_FAST, 0 selects DUTY_SLOW.
- estop, in, 1: synchronous emergency stop, level-sensitive, highest priority.
- MOTOR, out, 3: [1:0] direction, [2] PWM.
- busy, out, 1: state is not IDLE and not RUN.
- state_o, out, 3: current state encoding.

## Operation
- Period counter counts 0..PERIOD-1 and wraps. period_tick is 1 in the cycle when counter == PERIOD-1.
- MOTOR[2] is a register loaded with (counter < duty). duty is 32-bit unsigned and changes only on period_tick.
- Ramp rule on period_tick: if duty < target, duty = min(duty+RAMP_STEP, target); if duty > target, duty = max(duty-RAMP_STEP, target). Duty never overshoots the target or underflows.
- Target is 0 for a stop command, DUTY_FAST if cmd_fast is 1, otherwise DUTY_SLOW. cmd_dir 11 is treated as a stop.
- cmd_ready = 1 only in IDLE and RUN, and only when estop = 0. A command is accepted on cmd_valid & cmd_ready. Commands offered in any other state wait; they are not dropped.
- States and encodings:
  - IDLE (0):
    - Stop command: stays in IDLE.
    - Run command: dir_reg = cmd_dir, target latched, go to RAMP.
  - RAMP (1): when duty == target (checked every cycle), go to RUN.
  - RUN (2):
    - Command with the same nonzero direction: new target, go to RAMP, direction lines unchanged.
    - Otherwise: pend_dir = cmd_dir (00 for stop), pend_target latched, target = 0, go to RAMP_DOWN.
  - RAMP_DOWN (3): when duty == 0, dir_reg = 00, dead counter cleared, go to DEAD.
  - DEAD (4): dead counter increments on each period_tick. When it reaches DEAD_PERIODS:
    - pend_dir == 00: go to IDLE.
    - Otherwise: dir_reg = pend_dir, target = pend_target, go to RAMP.
- estop = 1 in any state, effective on the next edge:
  - duty = 0, dir_reg = 00, pend_dir = 00, dead counter cleared, state DEAD.
  - While estop stays 1, the dead counter is held at 0.
  - After estop is released, the full dead-time runs, then the block goes to IDLE.
- MOTOR[1:0] = dir_reg. 11 is never driven.

## Timing
- Reset (rst_n = 0) acts immediately, without waiting for clk:
  - Outputs: MOTOR = 000, state IDLE, cmd_ready = 1, busy = 0.
  - Internal: counter = 0, duty = 0, target = 0, dir_reg = 00, dead counter = 0.
- Reset asserted mid-operation, including mid-PWM-high, gives the same result.
- A command accepted at edge T: state and dir_reg are updated at edge T+1.
- MOTOR[2] lags the counter/duty compare by 1 cycle.
- A duty change lands on the first period_tick after the state has entered RAMP or RAMP_DOWN. A partial period never carries a changed duty.
- Dead-time is exactly DEAD_PERIODS period_ticks, counted from the first tick after entering DEAD.
- Direction lines change only on entry to DEAD (to 00), on exit from DEAD, or on acceptance in IDLE. A same-direction retarget never touches them.
- period_tick coinciding with a command acceptance: the ramp step uses the old target, and the new target applies from the next tick.

## Test plan
Bench parameters for all scenarios: PERIOD=10, DUTY_SLOW=2, DUTY_FAST=9, RAMP_STEP=3, DEAD_PERIODS=2.
- Reset: hold rst_n = 0 -> MOTOR = 000, cmd_ready = 1, busy = 0, state_o = 0. Release, no command -> MOTOR stays 000 for 50 cycles.
- Start from IDLE with dir = 01, fast = 0 -> MOTOR[1:0] = 01 one cycle after acceptance. Duty goes 0 to 2 at the first tick, then RUN. MOTOR[2] is high for exactly 2 of every 10 cycles.
- From RUN slow, command dir = 01, fast = 1 -> duty goes 2, 5, 8, 9 over 3 ticks, then RUN. MOTOR[1:0] stays 01 throughout.
- Reverse from RUN forward fast (dir = 10) -> duty goes 9, 6, 3, 0. MOTOR[1:0] = 00 for 2 full periods, then 10. Duty goes 0 to 2, then RUN. cmd_ready = 0 throughout, and a concurrent cmd_valid is held until RUN.
- estop pulsed during RAMP -> MOTOR = 000 on the next edge, state_o = 4. The block reaches IDLE 2 ticks after estop drops. cmd_ready = 0 until then.
- rst_n dropped mid-DEAD and mid-PWM-high -> MOTOR = 000 without waiting for clk. After release the block is in IDLE and accepts a new forward command normally.

Source files
------------

// File: rtl/motor_ramp_sequencer_if.sv
// Command channel into the motor ramp sequencer: speed/direction requests
// from the switch/command decode logic.
interface motor_cmd_if;
  // A command transfers on a rising edge where cmd_valid and cmd_ready are both 1.
  // The master holds cmd_valid/cmd_dir/cmd_fast stable until then; cmd_ready may
  // drop at any time without the pending command being lost.
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dir;
  logic       cmd_fast;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_fast,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_fast,
    output cmd_ready
  );
endinterface

// File: rtl/motor_ramp_sequencer.sv
// Brushed-motor drive sequencer: ramps PWM duty once per period toward the
// commanded target, with ramp-down and dead-time around any direction change.
module motor_ramp_sequencer #(
  parameter logic [31:0] PERIOD       = 32'd1000000,
  parameter logic [31:0] DUTY_SLOW    = 32'd200000,
  parameter logic [31:0] DUTY_FAST    = 32'd900000,
  parameter logic [31:0] RAMP_STEP    = 32'd50000,
  parameter logic [31:0] DEAD_PERIODS = 32'd10
) (
  input  logic       clk,
  input  logic       rst_n,
  motor_cmd_if.slave cmd,
  input  logic       estop,
  output logic [2:0] MOTOR,
  output logic       busy,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP      = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    DEAD      = 3'd4
  } state_t;

  localparam logic [31:0] PERIOD_LAST = PERIOD - 32'd1;

  state_t      state, state_d;
  logic [31:0] cnt;
  logic [31:0] duty, duty_d;
  logic [31:0] target, target_d;
  logic [31:0] pend_target, pend_target_d;
  logic [31:0] dead_cnt, dead_cnt_d;
  logic [1:0]  dir_reg, dir_d;
  logic [1:0]  pend_dir, pend_dir_d;
  logic        pwm;
  logic        period_tick;
  logic        accept;
  logic        cmd_run;
  logic        same_dir;
  logic [31:0] cmd_target;
  logic [31:0] ramped;

  assign period_tick   = (cnt == PERIOD_LAST);
  assign cmd.cmd_ready = ((state == IDLE) || (state == RUN)) && !estop;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd_run       = (cmd.cmd_dir == 2'b01) || (cmd.cmd_dir == 2'b10);
  assign cmd_target    = !cmd_run ? 32'd0 : (cmd.cmd_fast ? DUTY_FAST : DUTY_SLOW);
  assign same_dir      = cmd_run && (cmd.cmd_dir == dir_reg);

  // Differences are compared before stepping so the duty never wraps or overshoots.
  always_comb begin
    ramped = duty;
    if (duty < target) begin
      ramped = ((target - duty) > RAMP_STEP) ? (duty + RAMP_STEP) : target;
    end else if (duty > target) begin
      ramped = ((duty - target) > RAMP_STEP) ? (duty - RAMP_STEP) : target;
    end
  end

  always_comb begin
    state_d       = state;
    dir_d         = dir_reg;
    target_d      = target;
    pend_dir_d    = pend_dir;
    pend_target_d = pend_target;
    dead_cnt_d    = dead_cnt;
    duty_d        = period_tick ? ramped : duty;
    if (estop) begin
      state_d       = DEAD;
      duty_d        = 32'd0;
      dir_d         = 2'b00;
      target_d      = 32'd0;
      pend_dir_d    = 2'b00;
      pend_target_d = 32'd0;
      dead_cnt_d    = 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && cmd_run) begin
            dir_d    = cmd.cmd_dir;
            target_d = cmd_target;
            state_d  = RAMP;
          end
        end
        RAMP: begin
          if (duty == target) state_d = RUN;
        end
        RUN: begin
          if (accept) begin
            if (same_dir) begin
              target_d = cmd_target;
              state_d  = RAMP;
            end else begin
              pend_dir_d    = cmd_run ? cmd.cmd_dir : 2'b00;
              pend_target_d = cmd_target;
              target_d      = 32'd0;
              state_d       = RAMP_DOWN;
            end
          end
        end
        RAMP_DOWN: begin
          if (duty == 32'd0) begin
            dir_d      = 2'b00;
            dead_cnt_d = 32'd0;
            state_d    = DEAD;
          end
        end
        DEAD: begin
          // Exit is evaluated on the cycle after the final tick so the lines sit at 00 for whole periods.
          if (dead_cnt == DEAD_PERIODS) begin
            if (pend_dir == 2'b00) begin
              state_d = IDLE;
            end else begin
              dir_d    = pend_dir;
              target_d = pend_target;
              state_d  = RAMP;
            end
          end else if (period_tick) begin
            dead_cnt_d = dead_cnt + 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      duty        <= 32'd0;
      target      <= 32'd0;
      pend_target <= 32'd0;
      dead_cnt    <= 32'd0;
      dir_reg     <= 2'b00;
      pend_dir    <= 2'b00;
    end else begin
      state       <= state_d;
      duty        <= duty_d;
      target      <= target_d;
      pend_target <= pend_target_d;
      dead_cnt    <= dead_cnt_d;
      dir_reg     <= dir_d;
      pend_dir    <= pend_dir_d;
    end
  end

  // PWM output is forced low by estop on the same edge that clears duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 32'd0;
      pwm <= 1'b0;
    end else begin
      cnt <= period_tick ? 32'd0 : (cnt + 32'd1);
      pwm <= estop ? 1'b0 : (cnt < duty);
    end
  end

  assign MOTOR   = {pwm, dir_reg};
  assign busy    = (state != IDLE) && (state != RUN);
  assign state_o = state;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed bench for motor_ramp_sequencer with a 10-cycle PWM period; duty is
// observed as the MOTOR[2] pattern over one period-aligned window.
module tb_motor_ramp_sequencer;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        estop = 1'b0;
  logic [2:0]  motor;
  logic        busy;
  logic [2:0]  state_o;
  int          n_eval = 0;
  int          n_fail = 0;
  int unsigned ncyc;

  motor_cmd_if cmd_bus ();

  motor_ramp_sequencer #(
    .PERIOD      (32'd10),
    .DUTY_SLOW   (32'd2),
    .DUTY_FAST   (32'd9),
    .RAMP_STEP   (32'd3),
    .DEAD_PERIODS(32'd2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd    (cmd_bus),
    .estop  (estop),
    .MOTOR  (motor),
    .busy   (busy),
    .state_o(state_o)
  );

  // clock / reset-relative cycle count (edges since reset release)
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] dir, input logic fast, input string tag);
    int g;
    g = 0;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_dir   = dir;
    cmd_bus.cmd_fast  = fast;
    while (cmd_bus.cmd_ready !== 1'b1 && g < 300) begin
      step();
      g++;
    end
    chk({tag, " ready"}, cmd_bus.cmd_ready, 1);
    step();
    cmd_bus.cmd_valid = 1'b0;
  endtask

  // Align to a period boundary, then sample MOTOR for one full period.
  task automatic window(input int d, input logic [1:0] dir, input logic chk_rdy, input string tag);
    logic [9:0] obs;
    logic [9:0] expv;
    int dir_mis;
    int rdy_hi;
    int g;
    obs = '0;
    expv = '0;
    dir_mis = 0;
    rdy_hi = 0;
    g = 0;
    while ((ncyc % 10) != 0 && g < 20) begin
      step();
      g++;
    end
    for (int i = 0; i < 10; i++) begin
      step();
      obs[i]  = motor[2];
      expv[i] = (i < d);
      if (motor[1:0] !== dir) dir_mis++;
      if (cmd_bus.cmd_ready !== 1'b0) rdy_hi++;
    end
    chk({tag, " pwm"}, obs, expv);
    chk({tag, " dir"}, dir_mis, 0);
    if (chk_rdy) chk({tag, " ready low"}, rdy_hi, 0);
  endtask

  initial begin
    int g;
    int bad;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_dir   = 2'b00;
    cmd_bus.cmd_fast  = 1'b0;

    // reset
    repeat (3) step();
    chk("rst motor", motor, 0);
    chk("rst ready", cmd_bus.cmd_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst state", state_o, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle motor", motor, 0);
    end

    // start forward slow
    send_cmd(2'b01, 1'b0, "start");
    chk("start dir", motor[1:0], 2'b01);
    chk("start state", state_o, 1);
    chk("start busy", busy, 1);
    window(2, 2'b01, 1'b0, "slow w1");
    chk("slow run state", state_o, 2);
    window(2, 2'b01, 1'b0, "slow w2");

    // same-direction retarget to fast
    send_cmd(2'b01, 1'b1, "fast");
    chk("fast state", state_o, 1);
    chk("fast dir", motor[1:0], 2'b01);
    window(5, 2'b01, 1'b0, "fast w5");
    window(8, 2'b01, 1'b0, "fast w8");
    window(9, 2'b01, 1'b0, "fast w9");
    chk("fast run state", state_o, 2);

    // reverse, with a second command held during ramp-down and dead-time
    send_cmd(2'b10, 1'b0, "rev");
    chk("rev state", state_o, 3);
    chk("rev dir kept", motor[1:0], 2'b01);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_dir   = 2'b10;
    cmd_bus.cmd_fast  = 1'b1;
    window(6, 2'b01, 1'b1, "rev w6");
    window(3, 2'b01, 1'b1, "rev w3");
    window(0, 2'b00, 1'b1, "dead w1");
    window(0, 2'b00, 1'b1, "dead w2");
    window(0, 2'b10, 1'b1, "rev w0");
    window(2, 2'b10, 1'b0, "rev w2");
    chk("held cmd accepted", state_o, 1);
    cmd_bus.cmd_valid = 1'b0;
    window(5, 2'b10, 1'b0, "held w5");

    // estop during RAMP
    estop = 1'b1;
    step();
    chk("estop motor", motor, 0);
    chk("estop state", state_o, 4);
    chk("estop ready", cmd_bus.cmd_ready, 0);
    chk("estop busy", busy, 1);
    step();
    step();
    estop = 1'b0;
    g = 0;
    bad = 0;
    while (state_o == 3'd4 && g < 100) begin
      if (cmd_bus.cmd_ready !== 1'b0 || motor !== 3'b000) bad++;
      step();
      g++;
    end
    chk("estop idle cycle", ncyc, 221);
    chk("estop idle state", state_o, 0);
    chk("estop quiet", bad, 0);
    chk("estop idle ready", cmd_bus.cmd_ready, 1);

    // reset during PWM high
    send_cmd(2'b01, 1'b1, "pre-rst");
    g = 0;
    while (ncyc < 231 && g < 50) begin
      step();
      g++;
    end
    chk("pwm high before rst", motor, 3'b101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst motor", motor, 0);
    chk("async rst state", state_o, 0);
    chk("async rst ready", cmd_bus.cmd_ready, 1);
    chk("async rst busy", busy, 0);
    step();
    step();
    rst_n = 1'b1;

    // stop into DEAD, then reset mid-dead-time
    send_cmd(2'b01, 1'b0, "run2");
    send_cmd(2'b00, 1'b0, "stop");
    chk("stop state", state_o, 3);
    g = 0;
    while (state_o != 3'd4 && g < 100) begin
      step();
      g++;
    end
    chk("stop dead cycle", ncyc, 21);
    chk("stop dead motor", motor, 0);
    g = 0;
    while (ncyc < 35 && g < 50) begin
      step();
      g++;
    end
    chk("mid dead state", state_o, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("dead rst state", state_o, 0);
    chk("dead rst ready", cmd_bus.cmd_ready, 1);
    step();
    step();
    rst_n = 1'b1;

    // normal start after reset
    send_cmd(2'b01, 1'b0, "restart");
    chk("restart dir", motor[1:0], 2'b01);
    chk("restart state", state_o, 1);
    window(2, 2'b01, 1'b0, "restart w2");
    chk("restart run", state_o, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
